dbus_bridge: RTL and testbench
==============================

Name: dbus_bridge

Overview:
- Memory-side responder for the datapath's data-access interface.
- Accepts the datapath's read and write requests (mread/mwrite), drives an SRAM-like data bus (req / addr_ok / data_ok), and returns aligned, extended read data on rd with a one-cycle d_data_ok completion pulse.
- Tracks one outstanding transaction at a time.
- On flush_ex, squashes the completion while still draining the bus transaction.

Parameters:
- ADDR_W, 32, width of request and bus address.
- WRITE_FIRST, 1, when both requests are valid in IDLE: 1 = serve write first, 0 = serve read first.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- mread_valid  input  1  read request; held stable by the datapath until d_data_ok.
- mread_addr  input  ADDR_W  read byte address.
- mread_size  input  2  0 = byte, 1 = half, 2/3 = word.
- mread_signed  input  1  sign-extend byte/half reads.
- mwrite_valid  input  1  write request; held stable until d_data_ok.
- mwrite_addr  input  ADDR_W  write byte address.
- mwrite_size  input  2  as mread_size.
- mwrite_data  input  32  right-justified store data.
- flush_ex  input  1  squash the in-flight or presented request.
- rd  output  32  extended read data; valid when d_data_ok=1, held until the next read completion.
- d_data_ok  output  1  one-cycle completion pulse for a read or write.
- busy  output  1  state != IDLE.
- data_req  output  1  bus request.
- data_wr  output  1  1 = write.
- data_size  output  2  latched size.
- data_addr  output  ADDR_W  latched address, low bits aligned to size.
- data_wstrb  output  4  byte enables.
- data_wdata  output  32  replicated store data.
- data_addr_ok  input  1  bus accepted the request.
- data_data_ok  input  1  bus completed; data_rdata valid.
- data_rdata  input  32  raw read word.

Behaviour:
- Reset:
  - state=IDLE; killed=0.
  - All outputs 0, including rd, d_data_ok, data_req, data_wstrb.
  - Reset mid-transaction abandons the transaction; the memory side shares the same reset.
- FSM states: IDLE, REQ, WAIT, DONE. All outputs are registered or Moore.
- IDLE:
  - flush_ex=1: ignore requests, stay in IDLE.
  - Otherwise, if a request is valid: latch addr/size/signed/data/wr and go to REQ.
  - Both requests valid: WRITE_FIRST picks which one is served; the other is served on a later IDLE visit.
- REQ:
  - data_req=1; address, size, wr, wstrb and wdata are stable from latched values.
  - data_addr_ok=1: go to WAIT.
  - data_data_ok while in REQ is ignored (protocol forbids it).
- WAIT:
  - data_req=0.
  - On data_data_ok: if killed=0, register the extended read into rd (reads only) and go to DONE.
  - If killed=1: rd is unchanged, go to IDLE, clear killed.
- DONE: d_data_ok=1 for exactly one cycle, then go to IDLE.
  - Because requests are sampled only in IDLE, the request held during DONE is never re-accepted.
- Flush:
  - flush_ex in REQ or WAIT sets killed.
  - The bus transaction always completes; writes are still performed.
  - Stores reach this block only after commit, so write squash never occurs in practice.
  - flush_ex in DONE does not retract d_data_ok.
- Minimum latency: request in IDLE at cycle 0, addr_ok at cycle 1, data_ok at cycle 2 → d_data_ok at cycle 3. Throughput is one access per 4 cycles.
- Alignment: low address bits are forced to zero per size (half: bit0; word: bits1:0). No exception is raised; misalignment is trapped upstream. data_size=3 is issued as 2.
- Write strobes and data:
  - byte: wstrb = 0001 << a[1:0], wdata = {4{d[7:0]}}.
  - half: wstrb = 0011 << (2*a[1]), wdata = {2{d[15:0]}}.
  - word: wstrb = 1111, wdata = d.
  - Reads drive wstrb = 0000.
- Read extraction:
  - byte = rdata[8*a[1:0] +: 8]; half = rdata[16*a[1] +: 16].
  - Zero- or sign-extended per latched signed; word is passed through.
- d_data_ok is asserted for writes too; rd is unchanged on write completion.

Test Plan:
- Word read 0x1000, bus addr_ok at +1, data_ok at +2 with rdata=0xDEADBEEF → data_req high 1 cycle, rd=0xDEADBEEF, d_data_ok pulse at cycle 3, busy low at cycle 4.
- Signed byte read addr 0x1003, rdata=0x80112233 → rd=0xFFFFFF80; same read unsigned → rd=0x00000080; half read addr 0x1002 unsigned → rd=0x00008011.
- Byte write addr 0x2001 data 0x000000AB → data_wr=1, wstrb=0010, wdata=0xABABABAB; half write 0x2003 → data_addr=0x2002, wstrb=1100.
- flush_ex asserted in WAIT for a read, data_ok 2 cycles later with 0x12345678 → no d_data_ok, rd keeps its previous value, next request accepted.
- mread_valid and mwrite_valid both high with WRITE_FIRST=1, addr_ok delayed 3 cycles → write issued first with data_req held stable for 4 cycles; read issued after DONE; exactly two d_data_ok pulses.
- reset asserted during REQ → next cycle data_req=0, busy=0, rd=0, d_data_ok=0.

Source files
------------

// File: rtl/dbus_bridge.sv
// dbus_bridge: memory-side responder for the datapath's data-access port.
// Takes one read or write request at a time from the datapath, issues it on an
// SRAM-like bus (req / addr_ok / data_ok), and returns aligned, extended read
// data with a one-cycle completion pulse.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   mread_*                read request (valid, byte address, size, signed)
//   mwrite_*               write request (valid, byte address, size, data)
//   flush_ex               squash the in-flight or presented request
//   rd                     extended read data, held until the next read completes
//   d_data_ok              one-cycle completion pulse (reads and writes)
//   busy                   transaction in progress
//   data_req/wr/size/addr/wstrb/wdata   bus request side
//   data_addr_ok/data_ok/rdata          bus response side
module dbus_bridge #(
  parameter int ADDR_W      = 32,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mread_valid,
  input  logic [ADDR_W-1:0] mread_addr,
  input  logic [1:0]        mread_size,
  input  logic              mread_signed,
  input  logic              mwrite_valid,
  input  logic [ADDR_W-1:0] mwrite_addr,
  input  logic [1:0]        mwrite_size,
  input  logic [31:0]       mwrite_data,
  input  logic              flush_ex,
  output logic [31:0]       rd,
  output logic              d_data_ok,
  output logic              busy,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              killed;
  logic              lat_signed;

  logic              take_req, take_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [3:0]        sel_wstrb;
  logic [31:0]       sel_wdata;
  logic              squash;
  logic [31:0]       rd_ext;

  // Request selection and bus-word formatting, done before latching so the
  // bus fields are plain registers while the request is outstanding.
  always_comb begin
    take_req  = (mread_valid | mwrite_valid) & ~flush_ex;
    take_wr   = mwrite_valid & (WRITE_FIRST | ~mread_valid);
    sel_addr  = take_wr ? mwrite_addr : mread_addr;
    sel_size  = take_wr ? mwrite_size : mread_size;
    if (sel_size == 2'd3) sel_size = 2'd2;
    sel_wstrb = '0;
    sel_wdata = '0;
    case (sel_size)
      2'd0: begin
        sel_wstrb = 4'b0001 << sel_addr[1:0];
        sel_wdata = {4{mwrite_data[7:0]}};
      end
      2'd1: begin
        sel_addr[0] = 1'b0;
        sel_wstrb   = sel_addr[1] ? 4'b1100 : 4'b0011;
        sel_wdata   = {2{mwrite_data[15:0]}};
      end
      default: begin
        sel_addr[1:0] = 2'b00;
        sel_wstrb     = 4'b1111;
        sel_wdata     = mwrite_data;
      end
    endcase
    if (!take_wr) begin
      sel_wstrb = '0;
      sel_wdata = '0;
    end
  end

  // A flush arriving in the same cycle as data_ok still squashes the completion.
  assign squash = killed | flush_ex;

  always_comb begin
    rd_ext = data_rdata;
    case (data_size)
      2'd0: begin
        rd_ext[7:0]  = data_rdata[8*data_addr[1:0] +: 8];
        rd_ext[31:8] = {24{lat_signed & rd_ext[7]}};
      end
      2'd1: begin
        rd_ext[15:0]  = data_rdata[16*data_addr[1] +: 16];
        rd_ext[31:16] = {16{lat_signed & rd_ext[15]}};
      end
      default: rd_ext = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take_req) state_nxt = REQ;
      REQ:  if (data_addr_ok) state_nxt = WAIT;
      WAIT: if (data_data_ok) state_nxt = squash ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_req  = (state == REQ);
    d_data_ok = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      killed     <= 1'b0;
      lat_signed <= 1'b0;
      rd         <= '0;
      data_wr    <= 1'b0;
      data_size  <= '0;
      data_addr  <= '0;
      data_wstrb <= '0;
      data_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (take_req) begin
            lat_signed <= mread_signed;
            data_wr    <= take_wr;
            data_size  <= sel_size;
            data_addr  <= sel_addr;
            data_wstrb <= sel_wstrb;
            data_wdata <= sel_wdata;
          end
        end
        REQ: if (flush_ex) killed <= 1'b1;
        WAIT: begin
          if (data_data_ok) begin
            killed <= 1'b0;
            if (!squash && !data_wr) rd <= rd_ext;
          end else if (flush_ex) begin
            killed <= 1'b1;
          end
        end
        default: killed <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Scoreboard bench for dbus_bridge: the stimulus process queues expected bus
// requests and expected completions; a bus responder and a completion monitor
// pop and compare independently.
module tb_dbus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mread_valid, mread_signed, mwrite_valid;
  logic [31:0] mread_addr, mwrite_addr, mwrite_data;
  logic [1:0]  mread_size, mwrite_size;
  logic        flush_ex, resp_flush, stim_flush;
  logic [31:0] rd;
  logic        d_data_ok, busy, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          a_dly;
    int          d_dly;
    int          fmode;   // 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in DONE
    bit          abort;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  assign flush_ex = resp_flush | stim_flush;

  always #5 clk = ~clk;

  dbus_bridge #(.ADDR_W(32), .WRITE_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mread_valid(mread_valid), .mread_addr(mread_addr), .mread_size(mread_size),
    .mread_signed(mread_signed),
    .mwrite_valid(mwrite_valid), .mwrite_addr(mwrite_addr), .mwrite_size(mwrite_size),
    .mwrite_data(mwrite_data),
    .flush_ex(flush_ex), .rd(rd), .d_data_ok(d_data_ok), .busy(busy),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte/half/word lanes picked by arithmetic on the address.
  function automatic logic [31:0] model_read(logic [31:0] w, logic [31:0] a,
                                             logic [1:0] sz, bit sgn);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (32'd8 * (a % 32'd4))) % 32'd256;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (w >> (32'd16 * ((a / 32'd2) % 32'd2))) % 32'd65536;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic bus_t make_bus(bit wr, logic [31:0] a, logic [1:0] sz,
                                    logic [31:0] d, logic [31:0] rdat,
                                    int ad, int dd, int fm);
    bus_t b;
    b.wr    = wr;
    b.rdata = rdat;
    b.a_dly = ad;
    b.d_dly = dd;
    b.fmode = fm;
    b.abort = 1'b0;
    b.size  = (sz == 2'd3) ? 2'd2 : sz;
    if (sz == 2'd0) begin
      b.addr  = a;
      b.wstrb = 4'(32'd1 << (a % 32'd4));
      b.wdata = (d % 32'd256) * 32'h01010101;
    end else if (sz == 2'd1) begin
      b.addr  = a - (a % 32'd2);
      b.wstrb = 4'(32'd3 << (32'd2 * ((a / 32'd2) % 32'd2)));
      b.wdata = (d % 32'd65536) * 32'h00010001;
    end else begin
      b.addr  = a - (a % 32'd4);
      b.wstrb = 4'hF;
      b.wdata = d;
    end
    if (!wr) b.wstrb = 4'h0;
    return b;
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic drive(bit wr, logic [31:0] a, logic [1:0] sz, bit sgn, logic [31:0] d);
    if (wr) begin
      mwrite_valid = 1'b1; mwrite_addr = a; mwrite_size = sz; mwrite_data = d;
    end else begin
      mread_valid = 1'b1; mread_addr = a; mread_size = sz; mread_signed = sgn;
    end
  endtask

  task automatic expect_done(bit wr, logic [31:0] a, logic [1:0] sz, bit sgn,
                             logic [31:0] rdat, int fm);
    if (fm == 0 || fm == 3) begin
      if (!wr) last_rd = model_read(rdat, a, sz, sgn);
      exp_q.push_back(last_rd);
    end
  endtask

  task automatic issue(bit wr, logic [31:0] a, logic [1:0] sz, bit sgn, logic [31:0] d,
                       logic [31:0] rdat, int ad, int dd, int fm, output int lat);
    @(negedge clk);
    bus_q.push_back(make_bus(wr, a, sz, d, rdat, ad, dd, fm));
    expect_done(wr, a, sz, sgn, rdat, fm);
    drive(wr, a, sz, sgn, d);
    wait_idle(lat);
    mread_valid  = 1'b0;
    mwrite_valid = 1'b0;
  endtask

  // Bus responder: checks each request against the queued expectation and
  // answers with the queued delays and read word.
  initial begin
    bus_t b;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; resp_flush = 1'b0;
    forever begin
      @(negedge clk);
      if (data_req) begin
        if (bus_q.size() == 0) begin
          check("unexpected_req", 32'(data_req), 32'd0);
        end else begin
          b = bus_q.pop_front();
          if (!b.abort) begin
            check("bus_addr", data_addr, b.addr);
            check("bus_wr", 32'(data_wr), 32'(b.wr));
            check("bus_size", 32'(data_size), 32'(b.size));
            check("bus_wstrb", 32'(data_wstrb), 32'(b.wstrb));
            if (b.wr) check("bus_wdata", data_wdata, b.wdata);
            resp_flush = (b.fmode == 1);
            for (int i = 0; i < b.a_dly; i++) begin
              @(negedge clk);
              resp_flush = 1'b0;
              check("req_held", 32'(data_req), 32'd1);
              check("addr_held", data_addr, b.addr);
            end
            data_addr_ok = 1'b1;
            @(negedge clk);
            data_addr_ok = 1'b0;
            resp_flush   = (b.fmode == 2);
            check("req_drop", 32'(data_req), 32'd0);
            for (int i = 0; i < b.d_dly; i++) begin
              @(negedge clk);
              resp_flush = 1'b0;
            end
            data_data_ok = 1'b1;
            data_rdata   = b.rdata;
            @(negedge clk);
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            resp_flush   = (b.fmode == 3);
            if (b.fmode == 3) begin
              @(negedge clk);
              resp_flush = 1'b0;
            end
          end
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (d_data_ok) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'(d_data_ok), 32'd0);
        else check("rd", rd, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] a, d, r;
    logic [1:0]  sz;
    int fm, dd;
    reset = 1'b1; stim_flush = 1'b0;
    mread_valid = 1'b0; mread_addr = '0; mread_size = '0; mread_signed = 1'b0;
    mwrite_valid = 1'b0; mwrite_addr = '0; mwrite_size = '0; mwrite_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rd", rd, 32'd0);
    check("rst_done", 32'(d_data_ok), 32'd0);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wstrb", 32'(data_wstrb), 32'd0);
    check("rst_addr", data_addr, 32'd0);
    reset = 1'b0;

    issue(0, 32'h1000, 2'd2, 0, 0, 32'hDEADBEEF, 0, 0, 0, lat);
    check("min_latency", 32'(lat), 32'd4);
    issue(0, 32'h1003, 2'd0, 1, 0, 32'h80112233, 0, 0, 0, lat);
    issue(0, 32'h1003, 2'd0, 0, 0, 32'h80112233, 1, 1, 0, lat);
    issue(0, 32'h1002, 2'd1, 0, 0, 32'h80112233, 0, 2, 0, lat);
    issue(1, 32'h2001, 2'd0, 0, 32'h000000AB, 0, 0, 0, 0, lat);
    issue(1, 32'h2003, 2'd1, 0, 32'h00001234, 0, 0, 0, 0, lat);
    issue(1, 32'h2007, 2'd3, 0, 32'hCAFEF00D, 0, 1, 0, 0, lat);
    issue(0, 32'h3000, 2'd2, 0, 0, 32'h12345678, 0, 2, 2, lat);
    issue(0, 32'h3004, 2'd2, 0, 0, 32'h0BADC0DE, 1, 0, 1, lat);
    issue(0, 32'h3009, 2'd1, 1, 0, 32'h9876F00F, 0, 0, 3, lat);

    // Flush while idle: the presented request is ignored.
    @(negedge clk);
    stim_flush = 1'b1;
    drive(0, 32'h4000, 2'd2, 0, 0);
    @(negedge clk);
    check("idle_flush_busy", 32'(busy), 32'd0);
    check("idle_flush_req", 32'(data_req), 32'd0);
    stim_flush = 1'b0;
    mread_valid = 1'b0;

    // Both valid: write first, read on the next idle visit.
    @(negedge clk);
    bus_q.push_back(make_bus(1, 32'h5002, 2'd1, 32'h0000BEEF, 0, 3, 0, 0));
    bus_q.push_back(make_bus(0, 32'h5001, 2'd0, 0, 32'h00C30000, 0, 1, 0));
    expect_done(1, 32'h5002, 2'd1, 0, 0, 0);
    expect_done(0, 32'h5001, 2'd0, 1, 32'h00C30000, 0);
    drive(1, 32'h5002, 2'd1, 0, 32'h0000BEEF);
    drive(0, 32'h5001, 2'd0, 1, 0);
    wait_idle(lat);
    mwrite_valid = 1'b0;
    wait_idle(lat);
    mread_valid = 1'b0;

    for (int k = 0; k < 40; k++) begin
      a  = $urandom;
      d  = $urandom;
      r  = $urandom;
      sz = 2'($urandom_range(0, 3));
      fm = $urandom_range(0, 7);
      fm = (fm < 5) ? 0 : fm - 4;
      dd = $urandom_range(0, 3);
      if (fm == 2 && dd == 0) dd = 1;
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), d, r,
            $urandom_range(0, 3), dd, fm, lat);
    end

    // Reset during REQ abandons the transaction.
    @(negedge clk);
    begin
      bus_t b;
      b = make_bus(0, 32'h6000, 2'd2, 0, 0, 0, 0, 0);
      b.abort = 1'b1;
      bus_q.push_back(b);
    end
    drive(0, 32'h6000, 2'd2, 0, 0);
    @(negedge clk);
    check("pre_reset_req", 32'(data_req), 32'd1);
    reset = 1'b1;
    mread_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(data_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd", rd, 32'd0);
    check("mid_rst_done", 32'(d_data_ok), 32'd0);
    reset = 1'b0;
    last_rd = '0;
    issue(0, 32'h7002, 2'd1, 1, 0, 32'hFFFE0001, 0, 0, 0, lat);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
